ex_operand_stage: RTL and testbench

ID/EX boundary stage of the 4-bit-register-address pipeline. It latches decoded instruction fields into the execute stage with freeze, flush and bubble control. It also detects load-use and no-forwarding data hazards and raises a stall toward IF/ID. The forwarding unit drives `sel_src1` and `sel_src2`; this block applies those selects to pick the final ALU operands from the latched register values, the MEM-stage ALU result or the WB value. It sits directly upstream of the forwarding unit and supplies it with `ex_src1` and `ex_src2`.

---
 rtl/ex_operand_stage.sv | 161 ++++++++++++++++
 tb/tb_ex_operand_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with freeze/flush/bubble control,
// load-use and no-forwarding hazard detection, and the final operand mux that
// applies the forwarding unit's selects to the latched register values.
module ex_operand_stage #(
   parameter int ADDR_LEN = 4,
   parameter int DATA_LEN = 32,
   parameter int CMD_LEN  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                flush,
   input  logic                forward_en,
   input  logic                id_valid,
   input  logic                id_wb_en,
   input  logic                id_mem_r_en,
   input  logic                id_mem_w_en,
   input  logic                id_b,
   input  logic                id_s,
   input  logic                id_imm,
   input  logic                id_two_src,
   input  logic [CMD_LEN-1:0]  id_exe_cmd,
   input  logic [DATA_LEN-1:0] id_pc,
   input  logic [DATA_LEN-1:0] id_val_rn,
   input  logic [DATA_LEN-1:0] id_val_rm,
   input  logic [11:0]         id_shift_operand,
   input  logic [ADDR_LEN-1:0] id_dst,
   input  logic [ADDR_LEN-1:0] id_src1,
   input  logic [ADDR_LEN-1:0] id_src2,
   input  logic [ADDR_LEN-1:0] mem_dst,
   input  logic                mem_wb_en,
   input  logic [1:0]          sel_src1,
   input  logic [1:0]          sel_src2,
   input  logic [DATA_LEN-1:0] mem_alu_res,
   input  logic [DATA_LEN-1:0] wb_value,
   output logic                ex_valid,
   output logic                ex_wb_en,
   output logic                ex_mem_r_en,
   output logic                ex_mem_w_en,
   output logic                ex_b,
   output logic                ex_s,
   output logic                ex_imm,
   output logic [CMD_LEN-1:0]  ex_exe_cmd,
   output logic [DATA_LEN-1:0] ex_pc,
   output logic [DATA_LEN-1:0] ex_val_rm_fwd,
   output logic [DATA_LEN-1:0] ex_op1,
   output logic [DATA_LEN-1:0] ex_op2,
   output logic [11:0]         ex_shift_operand,
   output logic [ADDR_LEN-1:0] ex_dst,
   output logic [ADDR_LEN-1:0] ex_src1,
   output logic [ADDR_LEN-1:0] ex_src2,
   output logic                hazard
);

   typedef struct packed {
      logic                valid;
      logic                wbEn;
      logic                memREn;
      logic                memWEn;
      logic                b;
      logic                s;
      logic                imm;
      logic [CMD_LEN-1:0]  exeCmd;
      logic [DATA_LEN-1:0] pc;
      logic [DATA_LEN-1:0] valRn;
      logic [DATA_LEN-1:0] valRm;
      logic [11:0]         shiftOperand;
      logic [ADDR_LEN-1:0] dst;
      logic [ADDR_LEN-1:0] src1;
      logic [ADDR_LEN-1:0] src2;
   } stage_t;

   stage_t stage_q, stage_d;
   logic matchEx, matchMem;
   logic [1:0] effSel1, effSel2;

   // Source-register comparison against the EX and MEM destinations; src2 only counts when the instruction really reads it
   always_comb begin
      matchEx  = (id_src1 == stage_q.dst) | (id_two_src & (id_src2 == stage_q.dst));
      matchMem = (id_src1 == mem_dst) | (id_two_src & (id_src2 == mem_dst));
   end

   // Stall request: load-use only when forwarding covers the rest, otherwise any pending write in EX or MEM
   always_comb begin
      hazard = 1'b0;
      if (id_valid) begin
         if (forward_en) begin
            hazard = stage_q.valid & stage_q.memREn & matchEx;
         end else begin
            hazard = (stage_q.valid & stage_q.wbEn & matchEx) | (mem_wb_en & matchMem);
         end
      end
   end

   // Next stage contents: freeze holds, flush or hazard inserts an all-zero bubble, otherwise capture ID
   always_comb begin
      stage_d = stage_q;
      if (!freeze) begin
         if (flush || hazard) begin
            stage_d = '0;
         end else begin
            stage_d.valid        = id_valid;
            stage_d.wbEn         = id_wb_en;
            stage_d.memREn       = id_mem_r_en;
            stage_d.memWEn       = id_mem_w_en;
            stage_d.b            = id_b;
            stage_d.s            = id_s;
            stage_d.imm          = id_imm;
            stage_d.exeCmd       = id_exe_cmd;
            stage_d.pc           = id_pc;
            stage_d.valRn        = id_val_rn;
            stage_d.valRm        = id_val_rm;
            stage_d.shiftOperand = id_shift_operand;
            stage_d.dst          = id_dst;
            stage_d.src1         = id_src1;
            stage_d.src2         = id_two_src ? id_src2 : '0;
         end
      end
   end

   // Pipeline register; reset empties the stage immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   // Forwarding operand mux; select 11 and disabled forwarding both fall back to the latched register value
   always_comb begin
      effSel1 = forward_en ? sel_src1 : 2'b00;
      effSel2 = forward_en ? sel_src2 : 2'b00;
      case (effSel1)
         2'b01:   ex_op1 = mem_alu_res;
         2'b10:   ex_op1 = wb_value;
         default: ex_op1 = stage_q.valRn;
      endcase
      case (effSel2)
         2'b01:   ex_op2 = mem_alu_res;
         2'b10:   ex_op2 = wb_value;
         default: ex_op2 = stage_q.valRm;
      endcase
      ex_val_rm_fwd = ex_op2;
   end

   assign ex_valid         = stage_q.valid;
   assign ex_wb_en         = stage_q.wbEn;
   assign ex_mem_r_en      = stage_q.memREn;
   assign ex_mem_w_en      = stage_q.memWEn;
   assign ex_b             = stage_q.b;
   assign ex_s             = stage_q.s;
   assign ex_imm           = stage_q.imm;
   assign ex_exe_cmd       = stage_q.exeCmd;
   assign ex_pc            = stage_q.pc;
   assign ex_shift_operand = stage_q.shiftOperand;
   assign ex_dst           = stage_q.dst;
   assign ex_src1          = stage_q.src1;
   assign ex_src2          = stage_q.src2;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed scenarios plus a randomized run
// checked against a per-instruction reference model of the stage.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze, flush, forward_en;
   logic        id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_two_src;
   logic [3:0]  id_exe_cmd;
   logic [31:0] id_pc, id_val_rn, id_val_rm;
   logic [11:0] id_shift_operand;
   logic [3:0]  id_dst, id_src1, id_src2, mem_dst;
   logic        mem_wb_en;
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] mem_alu_res, wb_value;
   logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm;
   logic [3:0]  ex_exe_cmd;
   logic [31:0] ex_pc, ex_val_rm_fwd, ex_op1, ex_op2;
   logic [11:0] ex_shift_operand;
   logic [3:0]  ex_dst, ex_src1, ex_src2;
   logic        hazard;

   int checks = 0;
   int errors = 0;

   ex_operand_stage #(.ADDR_LEN(4), .DATA_LEN(32), .CMD_LEN(4)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .forward_en(forward_en),
      .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
      .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
      .id_two_src(id_two_src), .id_exe_cmd(id_exe_cmd), .id_pc(id_pc),
      .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_shift_operand(id_shift_operand),
      .id_dst(id_dst), .id_src1(id_src1), .id_src2(id_src2), .mem_dst(mem_dst),
      .mem_wb_en(mem_wb_en), .sel_src1(sel_src1), .sel_src2(sel_src2),
      .mem_alu_res(mem_alu_res), .wb_value(wb_value), .ex_valid(ex_valid),
      .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
      .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm), .ex_exe_cmd(ex_exe_cmd), .ex_pc(ex_pc),
      .ex_val_rm_fwd(ex_val_rm_fwd), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_shift_operand(ex_shift_operand), .ex_dst(ex_dst), .ex_src1(ex_src1),
      .ex_src2(ex_src2), .hazard(hazard)
   );

   always #5 clk = ~clk;

   // One instruction as the execute stage should hold it
   typedef struct packed {
      logic        valid, wbEn, memREn, memWEn, b, s, imm;
      logic [3:0]  cmd;
      logic [31:0] pc, rn, rm;
      logic [11:0] sh;
      logic [3:0]  dst, src1, src2;
   } instr_t;

   instr_t model;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setId(input logic v, input logic wb, input logic mr, input logic [3:0] dst,
                        input logic [3:0] s1, input logic [3:0] s2, input logic two,
                        input logic [31:0] rn, input logic [31:0] rm);
      id_valid = v; id_wb_en = wb; id_mem_r_en = mr; id_mem_w_en = 1'b0;
      id_b = 1'b0; id_s = 1'b0; id_imm = 1'b0; id_two_src = two;
      id_exe_cmd = 4'h2; id_pc = 32'h100; id_val_rn = rn; id_val_rm = rm;
      id_shift_operand = 12'h0; id_dst = dst; id_src1 = s1; id_src2 = s2;
   endtask

   task automatic test_reset();
      logic [66:0] outs;
      freeze = 0; flush = 0; forward_en = 1; mem_wb_en = 0; mem_dst = 0;
      sel_src1 = 0; sel_src2 = 0; mem_alu_res = 0; wb_value = 0;
      {id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_two_src} = '1;
      id_exe_cmd = '1; id_pc = '1; id_val_rn = '1; id_val_rm = '1;
      id_shift_operand = '1; id_dst = '1; id_src1 = '1; id_src2 = '1;
      #2 rst = 1'b0;
      #1;
      outs = {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm, ex_exe_cmd,
              ex_pc, ex_shift_operand, ex_dst, ex_src1, ex_src2};
      checks++;
      if (outs !== 67'h0) begin
         errors++; $display("[TB] FAIL reset_regs: got %h expected 0", outs);
      end
      checks++;
      if ({ex_op1, ex_val_rm_fwd} !== 64'h0) begin
         errors++; $display("[TB] FAIL reset_ops: got %h/%h expected 0", ex_op1, ex_val_rm_fwd);
      end
      checks++;
      if (hazard !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_hazard: got %b expected 0", hazard);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      checks++;
      if ({ex_dst, ex_valid} !== {4'hF, 1'b1}) begin
         errors++; $display("[TB] FAIL reset_release: got dst=%h valid=%b expected F/1", ex_dst, ex_valid);
      end
   endtask

   task automatic test_forward_mux();
      forward_en = 1;
      setId(1, 1, 0, 4'h9, 4'h1, 4'h2, 1, 32'h11, 32'h22);
      tick();
      setId(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h0, 32'h0);
      freeze = 1;
      mem_alu_res = 32'hAA; wb_value = 32'hBB; sel_src1 = 2'b01; sel_src2 = 2'b10;
      #1;
      checks++;
      if ({ex_op1, ex_op2, ex_val_rm_fwd} !== {32'hAA, 32'hBB, 32'hBB}) begin
         errors++; $display("[TB] FAIL fwd_sel: got %h %h %h expected AA BB BB", ex_op1, ex_op2, ex_val_rm_fwd);
      end
      forward_en = 0;
      #1;
      checks++;
      if ({ex_op1, ex_op2, ex_val_rm_fwd} !== {32'h11, 32'h22, 32'h22}) begin
         errors++; $display("[TB] FAIL fwd_disabled: got %h %h %h expected 11 22 22", ex_op1, ex_op2, ex_val_rm_fwd);
      end
      forward_en = 1; sel_src1 = 2'b11; sel_src2 = 2'b11;
      #1;
      checks++;
      if ({ex_op1, ex_op2, ex_val_rm_fwd} !== {32'h11, 32'h22, 32'h22}) begin
         errors++; $display("[TB] FAIL fwd_sel11: got %h %h %h expected 11 22 22", ex_op1, ex_op2, ex_val_rm_fwd);
      end
      sel_src1 = 0; sel_src2 = 0; freeze = 0;
   endtask

   task automatic test_load_use();
      forward_en = 1;
      setId(1, 1, 1, 4'h3, 4'h0, 4'h0, 0, 32'h0, 32'h0);
      tick();
      setId(1, 1, 0, 4'h4, 4'h3, 4'h0, 0, 32'h5, 32'h6);
      #1;
      checks++;
      if (hazard !== 1'b1) begin
         errors++; $display("[TB] FAIL loaduse_detect: got %b expected 1", hazard);
      end
      tick();
      checks++;
      if ({ex_valid, hazard} !== 2'b00) begin
         errors++; $display("[TB] FAIL loaduse_bubble: got valid=%b hazard=%b expected 0/0", ex_valid, hazard);
      end
      tick();
      checks++;
      if ({ex_src1, ex_valid} !== {4'h3, 1'b1}) begin
         errors++; $display("[TB] FAIL loaduse_resume: got src1=%h valid=%b expected 3/1", ex_src1, ex_valid);
      end
   endtask

   task automatic test_no_forward();
      forward_en = 0; mem_wb_en = 0;
      setId(1, 1, 0, 4'h5, 4'h0, 4'h0, 0, 32'h0, 32'h0);
      tick();
      setId(1, 1, 0, 4'h6, 4'h1, 4'h5, 1, 32'h7, 32'h8);
      #1;
      checks++;
      if (hazard !== 1'b1) begin
         errors++; $display("[TB] FAIL nofwd_ex_match: got %b expected 1", hazard);
      end
      tick();
      mem_dst = 4'h5; mem_wb_en = 1;
      #1;
      checks++;
      if ({ex_valid, hazard} !== 2'b01) begin
         errors++; $display("[TB] FAIL nofwd_mem_match: got valid=%b hazard=%b expected 0/1", ex_valid, hazard);
      end
      tick();
      mem_wb_en = 0; mem_dst = 0;
      #1;
      checks++;
      if ({ex_valid, hazard} !== 2'b00) begin
         errors++; $display("[TB] FAIL nofwd_clear: got valid=%b hazard=%b expected 0/0", ex_valid, hazard);
      end
      tick();
      checks++;
      if ({ex_valid, ex_src2, ex_dst} !== {1'b1, 4'h5, 4'h6}) begin
         errors++; $display("[TB] FAIL nofwd_load: got valid=%b src2=%h dst=%h expected 1/5/6", ex_valid, ex_src2, ex_dst);
      end
   endtask

   task automatic test_freeze_flush();
      freeze = 1; flush = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({ex_valid, ex_wb_en, ex_dst, ex_src2} !== {1'b1, 1'b1, 4'h6, 4'h5}) begin
            errors++; $display("[TB] FAIL freeze_hold%0d: got %b%b %h %h expected 1 1 6 5", i, ex_valid, ex_wb_en, ex_dst, ex_src2);
         end
      end
      freeze = 0;
      tick();
      flush = 0;
      checks++;
      if ({ex_valid, ex_wb_en} !== 2'b00) begin
         errors++; $display("[TB] FAIL flush_bubble: got valid=%b wb_en=%b expected 0/0", ex_valid, ex_wb_en);
      end
   endtask

   task automatic test_two_src();
      forward_en = 1;
      setId(1, 1, 1, 4'h7, 4'h0, 4'h0, 0, 32'h0, 32'h0);
      tick();
      setId(1, 1, 0, 4'h8, 4'h1, 4'h7, 0, 32'h0, 32'h0);
      #1;
      checks++;
      if (hazard !== 1'b0) begin
         errors++; $display("[TB] FAIL twosrc_nohazard: got %b expected 0", hazard);
      end
      tick();
      checks++;
      if ({ex_valid, ex_src2} !== {1'b1, 4'h0}) begin
         errors++; $display("[TB] FAIL twosrc_src2zero: got valid=%b src2=%h expected 1/0", ex_valid, ex_src2);
      end
   endtask

   task automatic test_reset_mid_stall();
      forward_en = 1;
      setId(1, 1, 1, 4'hA, 4'h0, 4'h0, 0, 32'h0, 32'h0);
      tick();
      setId(1, 1, 0, 4'hB, 4'hA, 4'h0, 0, 32'h0, 32'h0);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({ex_valid, ex_mem_r_en, hazard} !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_mid_stall: got %b%b%b expected 000", ex_valid, ex_mem_r_en, hazard);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Expected stall request computed from the hazard rules on the modelled EX instruction
   function automatic logic modelHazard();
      logic usesEx, usesMem;
      usesEx  = (id_src1 == model.dst) || (id_two_src && id_src2 == model.dst);
      usesMem = (id_src1 == mem_dst) || (id_two_src && id_src2 == mem_dst);
      if (!id_valid) return 1'b0;
      if (forward_en) return model.valid && model.memREn && usesEx;
      return (model.valid && model.wbEn && usesEx) || (mem_wb_en && usesMem);
   endfunction

   function automatic logic [31:0] pickOperand(input logic [1:0] sel, input logic [31:0] regVal);
      if (forward_en && sel == 2'd1) return mem_alu_res;
      if (forward_en && sel == 2'd2) return wb_value;
      return regVal;
   endfunction

   task automatic test_random();
      instr_t incoming;
      logic   expHz;
      int     badBefore;
      badBefore = errors;
      mem_wb_en = 0; freeze = 0; flush = 0;
      rst = 1'b0;
      #1;
      model = '0;
      rst = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         {id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_two_src} = 8'($urandom);
         id_exe_cmd = 4'($urandom); id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom;
         id_shift_operand = 12'($urandom);
         id_dst = 4'($urandom_range(0, 3)); id_src1 = 4'($urandom_range(0, 3));
         id_src2 = 4'($urandom_range(0, 3)); mem_dst = 4'($urandom_range(0, 3));
         mem_wb_en = 1'($urandom); forward_en = 1'($urandom);
         freeze = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 7) == 0);
         sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
         mem_alu_res = $urandom; wb_value = $urandom;
         #2;
         expHz = modelHazard();
         checks++;
         if (hazard !== expHz) begin
            errors++; $display("[TB] FAIL rand_hazard cyc%0d: got %b expected %b", cyc, hazard, expHz);
         end
         checks++;
         if ({ex_op1, ex_op2, ex_val_rm_fwd} !== {pickOperand(sel_src1, model.rn),
               pickOperand(sel_src2, model.rm), pickOperand(sel_src2, model.rm)}) begin
            errors++; $display("[TB] FAIL rand_operands cyc%0d: got %h %h %h", cyc, ex_op1, ex_op2, ex_val_rm_fwd);
         end
         incoming = '{id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_exe_cmd,
                      id_pc, id_val_rn, id_val_rm, id_shift_operand, id_dst, id_src1,
                      id_two_src ? id_src2 : 4'h0};
         @(posedge clk);
         if (!freeze) model = (flush || expHz) ? instr_t'('0) : incoming;
         #1;
         checks++;
         if ({ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm, ex_exe_cmd, ex_pc,
              ex_shift_operand, ex_dst, ex_src1, ex_src2} !==
             {model.valid, model.wbEn, model.memREn, model.memWEn, model.b, model.s, model.imm,
              model.cmd, model.pc, model.sh, model.dst, model.src1, model.src2}) begin
            errors++; $display("[TB] FAIL rand_state cyc%0d: got valid=%b dst=%h src1=%h src2=%h pc=%h expected valid=%b dst=%h src1=%h src2=%h pc=%h",
                               cyc, ex_valid, ex_dst, ex_src1, ex_src2, ex_pc,
                               model.valid, model.dst, model.src1, model.src2, model.pc);
         end
         if (errors - badBefore > 10) break;
      end
      freeze = 0; flush = 0; mem_wb_en = 0;
   endtask

   initial begin
      $display("[TB] starting ex_operand_stage bench");
      test_reset();
      test_forward_mux();
      test_load_use();
      test_no_forward();
      test_freeze_flush();
      test_two_src();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
